// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage / register file slice.
// Holds default widths and depth, the hard-wired zero register number,
// and the reset value used for storage and staging data.
package wb_regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 32;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam logic [31:0] RESET_DATA = 32'd0;

endpackage

// File: rtl/wb_regfile_array.sv
// regfile_array: NUM_REGS x DATA_WIDTH register storage.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high clear
//   we, waddr, wdata  - single synchronous write port
//   raddr_a/raddr_b   - combinational raw read addresses
//   rdata_a/rdata_b   - raw array contents (no forwarding, no zero masking)
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_WIDTH'(RESET_DATA);
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus register file.
// A write (dest_in/data_in qualified by reg_write_in) is staged for one
// cycle, then committed into the array. Two combinational read ports
// forward from the staged write; register 0 always reads zero.
// Ports:
//   clock_in, reset_in            - clock, asynchronous active-high reset
//   dest_in, data_in, reg_write_in - incoming writeback request
//   stall_in, flush_in            - hold staging / drop incoming write
//   read_addr_a_in/_b_in          - read addresses from decode
//   read_data_a_out/_b_out        - read data (forwarded or from array)
//   pending_out, pending_addr_out - staged write not yet in the array
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] dest_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  reg_write_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] read_addr_a_in,
  input  logic [ADDR_WIDTH-1:0] read_addr_b_in,
  output logic [DATA_WIDTH-1:0] read_data_a_out,
  output logic [DATA_WIDTH-1:0] read_data_b_out,
  output logic                  pending_out,
  output logic [ADDR_WIDTH-1:0] pending_addr_out
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = DATA_WIDTH'(RESET_DATA);

  logic                  s_valid_d, s_valid_q;
  logic [ADDR_WIDTH-1:0] s_addr_d,  s_addr_q;
  logic [DATA_WIDTH-1:0] s_data_d,  s_data_q;
  logic [DATA_WIDTH-1:0] raw_a, raw_b;

  // Zero register: port reads 0. Staged hit: forward staged data.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] raw,
    input logic                  valid,
    input logic [ADDR_WIDTH-1:0] st_addr,
    input logic [DATA_WIDTH-1:0] st_data
  );
    if (addr == ZERO_ADDR)              return ZERO_DATA;
    else if (valid && st_addr == addr)  return st_data;
    else                                return raw;
  endfunction

  // Staging update: flush beats stall; writes to reg 0 never stage.
  always_comb begin
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_data_d  = s_data_q;
    if (flush_in) begin
      s_valid_d = 1'b0;
    end else if (!stall_in) begin
      s_valid_d = reg_write_in && (dest_in != ZERO_ADDR);
      s_addr_d  = dest_in;
      s_data_d  = data_in;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      s_valid_q <= 1'b0;
      s_addr_q  <= ZERO_ADDR;
      s_data_q  <= ZERO_DATA;
    end else begin
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_data_q  <= s_data_d;
    end
  end

  // Commit is driven straight from the staging register, so it still
  // happens on stalled or flushed edges (re-committing the same value).
  regfile_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_array (
    .clk     (clock_in),
    .rst     (reset_in),
    .we      (s_valid_q),
    .waddr   (s_addr_q),
    .wdata   (s_data_q),
    .raddr_a (read_addr_a_in),
    .raddr_b (read_addr_b_in),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  assign read_data_a_out  = read_port(read_addr_a_in, raw_a, s_valid_q, s_addr_q, s_data_q);
  assign read_data_b_out  = read_port(read_addr_b_in, raw_b, s_valid_q, s_addr_q, s_data_q);
  assign pending_out      = s_valid_q;
  assign pending_addr_out = s_addr_q;

endmodule
